util_axis2msi_arb: RTL and testbench

UTIL_AXIS2MSI_ARB -- requirements
Module: util_axis2msi_arb

---
 rtl/util_axis2msi_arb_if.sv | 31 +++
 rtl/util_axis2msi_arb.sv | 114 +++++++++++
 tb/tb_util_axis2msi_arb.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/util_axis2msi_arb_if.sv
// rtl/util_axis2msi_arb_if.sv - event stream and MSI request bundle for util_axis2msi_arb
// Ports (slave = arbiter side):
//   s_axis_tdata/tvalid/tready : event stream, tdata carries the MSI vector number
//   msi_enable, msi_mask       : global issue enable and per-vector hold mask
//   msi_num, msi_req, msi_grant: request to / single-cycle grant from the MSI controller
//   pending, drop_count        : pending bitmap and saturating out-of-range event count
interface util_axis2msi_arb_if #(
    parameter int NUM_VECTORS = 32,
    parameter int CNT_WIDTH   = 16
);
    logic [7:0]             s_axis_tdata;
    logic                   s_axis_tvalid;
    logic                   s_axis_tready;
    logic                   msi_enable;
    logic [NUM_VECTORS-1:0] msi_mask;
    logic [4:0]             msi_num;
    logic                   msi_req;
    logic                   msi_grant;
    logic [NUM_VECTORS-1:0] pending;
    logic [CNT_WIDTH-1:0]   drop_count;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, msi_enable, msi_mask, msi_grant,
        output s_axis_tready, msi_num, msi_req, pending, drop_count
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, msi_enable, msi_mask, msi_grant,
        input  s_axis_tready, msi_num, msi_req, pending, drop_count
    );
endinterface

// File: rtl/util_axis2msi_arb.sv
// rtl/util_axis2msi_arb.sv - coalesces stream events into pending MSI vectors and issues them round-robin
// Ports:
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : util_axis2msi_arb_if.slave (event stream, MSI request/grant, status)
module util_axis2msi_arb #(
    parameter int NUM_VECTORS = 32,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    util_axis2msi_arb_if.slave   bus
);
    localparam int                IDX_W = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
    localparam logic [8:0]        NV9   = 9'(NUM_VECTORS);
    localparam logic [IDX_W-1:0]  LAST  = IDX_W'(NUM_VECTORS - 1);

    typedef enum logic {IDLE, REQ} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_tready;
    logic                   r_req;
    logic [IDX_W-1:0]       r_num;
    logic [IDX_W-1:0]       r_start;     // first index of the next round-robin search
    logic [NUM_VECTORS-1:0] r_pending;
    logic [CNT_WIDTH-1:0]   r_drop;

    logic                   w_accept;
    logic                   w_in_range;
    logic                   w_issue;
    logic                   w_found;
    logic [IDX_W-1:0]       w_sel;
    logic [NUM_VECTORS-1:0] w_elig;
    logic [NUM_VECTORS-1:0] w_set;
    logic [NUM_VECTORS-1:0] w_clr;

    assign w_accept   = bus.s_axis_tvalid & r_tready;
    assign w_in_range = {1'b0, bus.s_axis_tdata} < NV9;
    assign w_set      = (w_accept && w_in_range) ? (NUM_VECTORS'(1) << bus.s_axis_tdata) : '0;
    assign w_clr      = w_issue ? (NUM_VECTORS'(1) << w_sel) : '0;
    assign w_elig     = r_pending & ~bus.msi_mask;

    // Scan from r_start upwards with wrap; the first eligible vector wins.
    always_comb begin
        int k;
        k       = 0;
        w_found = 1'b0;
        w_sel   = '0;
        for (int i = 0; i < NUM_VECTORS; i++) begin
            k = int'(r_start) + i;
            if (k >= NUM_VECTORS) begin
                k = k - NUM_VECTORS;
            end
            if (!w_found && w_elig[k[IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_sel   = k[IDX_W-1:0];
            end
        end
    end

    // Enable and mask only gate a new selection; an issued request runs to grant.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.msi_enable && w_found) begin
                    w_issue     = 1'b1;
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                if (bus.msi_grant) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_tready  <= 1'b0;
            r_req     <= 1'b0;
            r_num     <= '0;
            r_start   <= '0;
            r_pending <= '0;
            r_drop    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_tready <= 1'b1;
            // A set in the issue cycle overrides the clear, so the vector fires again later.
            r_pending <= (r_pending & ~w_clr) | w_set;
            if (w_accept && !w_in_range && (r_drop != '1)) begin
                r_drop <= r_drop + CNT_WIDTH'(1);
            end
            if (w_issue) begin
                r_req <= 1'b1;
                r_num <= w_sel;
            end else if (r_state == REQ && bus.msi_grant) begin
                r_req   <= 1'b0;
                r_start <= (r_num == LAST) ? '0 : r_num + IDX_W'(1);
            end
        end
    end

    assign bus.s_axis_tready = r_tready;
    assign bus.msi_req       = r_req;
    assign bus.msi_num       = 5'(r_num);
    assign bus.pending       = r_pending;
    assign bus.drop_count    = r_drop;
endmodule

// File: tb/tb_util_axis2msi_arb.sv
// tb/tb_util_axis2msi_arb.sv - directed table and sequence bench for util_axis2msi_arb
module tb_util_axis2msi_arb;
    localparam int NV = 32;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    util_axis2msi_arb_if #(.NUM_VECTORS(NV), .CNT_WIDTH(CW)) bus ();

    util_axis2msi_arb #(.NUM_VECTORS(NV), .CNT_WIDTH(CW)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        tvalid;
        logic [7:0]  tdata;
        logic        en;
        logic [31:0] mask;
        logic        grant;
        logic        exp_req;
        logic [4:0]  exp_num;
        logic [31:0] exp_pend;
        logic [3:0]  exp_drop;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic v, input logic [7:0] d, input logic en, input logic [31:0] m,
                       input logic g, input logic er, input logic [4:0] en_num,
                       input logic [31:0] ep, input logic [3:0] ed);
        vec_t t;
        t.tvalid = v; t.tdata = d; t.en = en; t.mask = m; t.grant = g;
        t.exp_req = er; t.exp_num = en_num; t.exp_pend = ep; t.exp_drop = ed;
        tbl.push_back(t);
    endtask

    task automatic beat(input logic [7:0] d);
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tdata  = d;
        step();
        bus.s_axis_tvalid = 1'b0;
    endtask

    task automatic wait_req(input string name);
        for (int i = 0; i < 10; i++) begin
            if (bus.msi_req) break;
            step();
        end
        chk({name, "_req_seen"}, 32'(bus.msi_req), 32'd1);
    endtask

    task automatic grant(input string name);
        bus.msi_grant = 1'b1;
        step();
        bus.msi_grant = 1'b0;
        chk({name, "_req_dropped"}, 32'(bus.msi_req), 32'd0);
    endtask

    initial begin
        bus.s_axis_tdata  = '0;
        bus.s_axis_tvalid = 1'b0;
        bus.msi_enable    = 1'b1;
        bus.msi_mask      = '0;
        bus.msi_grant     = 1'b0;

        //   v  data en mask          g | req num pend          drop
        add(1, 3,  1, 32'h0,        0,  0, 0, 32'h0000_0008, 0);
        add(0, 0,  1, 32'h0,        0,  1, 3, 32'h0,         0);
        add(0, 0,  1, 32'h0,        0,  1, 3, 32'h0,         0);
        add(0, 0,  1, 32'h0,        1,  0, 3, 32'h0,         0);
        add(1, 1,  1, 32'h0,        0,  0, 3, 32'h0000_0002, 0);
        add(1, 5,  1, 32'h0,        0,  1, 1, 32'h0000_0020, 0);
        add(1, 5,  1, 32'h0,        0,  1, 1, 32'h0000_0020, 0);
        add(1, 5,  1, 32'h0,        1,  0, 1, 32'h0000_0020, 0);
        add(0, 0,  1, 32'h0,        0,  1, 5, 32'h0,         0);
        add(0, 0,  1, 32'h0,        1,  0, 5, 32'h0,         0);
        add(0, 0,  1, 32'h0,        0,  0, 5, 32'h0,         0);
        add(1, 40, 1, 32'h0,        0,  0, 5, 32'h0,         1);
        add(1, 40, 1, 32'h0,        0,  0, 5, 32'h0,         2);
        add(1, 40, 1, 32'h0,        0,  0, 5, 32'h0,         3);
        add(0, 0,  1, 32'h0,        1,  0, 5, 32'h0,         3);
        add(1, 9,  0, 32'h0,        0,  0, 5, 32'h0000_0200, 3);
        add(0, 0,  0, 32'h0,        0,  0, 5, 32'h0000_0200, 3);
        add(0, 0,  1, 32'h0,        0,  1, 9, 32'h0,         3);
        add(0, 0,  0, 32'hFFFF_FFFF, 0, 1, 9, 32'h0,         3);
        add(0, 0,  1, 32'h0,        1,  0, 9, 32'h0,         3);

        // Reset state
        #2;
        chk("rst_req", 32'(bus.msi_req), 32'd0);
        chk("rst_tready", 32'(bus.s_axis_tready), 32'd0);
        step();
        chk("rst_pending", bus.pending, 32'd0);
        chk("rst_drop", 32'(bus.drop_count), 32'd0);
        chk("rst_num", 32'(bus.msi_num), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("rel_tready", 32'(bus.s_axis_tready), 32'd1);

        // Table
        for (int i = 0; i < tbl.size(); i++) begin
            bus.s_axis_tvalid = tbl[i].tvalid;
            bus.s_axis_tdata  = tbl[i].tdata;
            bus.msi_enable    = tbl[i].en;
            bus.msi_mask      = tbl[i].mask;
            bus.msi_grant     = tbl[i].grant;
            step();
            chk($sformatf("vec%0d_req", i), 32'(bus.msi_req), 32'(tbl[i].exp_req));
            chk($sformatf("vec%0d_num", i), 32'(bus.msi_num), 32'(tbl[i].exp_num));
            chk($sformatf("vec%0d_pend", i), bus.pending, tbl[i].exp_pend);
            chk($sformatf("vec%0d_drop", i), 32'(bus.drop_count), 32'(tbl[i].exp_drop));
        end
        bus.s_axis_tvalid = 1'b0;
        bus.msi_grant     = 1'b0;
        bus.msi_mask      = '0;
        bus.msi_enable    = 1'b1;

        // Round robin: last grant 7, then 2/7/30 pending -> 30, 2, 7
        beat(8'd7);
        wait_req("rr_pre");
        chk("rr_pre_num", 32'(bus.msi_num), 32'd7);
        grant("rr_pre");
        bus.msi_enable = 1'b0;
        beat(8'd2);
        beat(8'd7);
        beat(8'd30);
        chk("rr_pending", bus.pending, 32'h4000_0084);
        bus.msi_enable = 1'b1;
        wait_req("rr0");
        chk("rr0_num", 32'(bus.msi_num), 32'd30);
        grant("rr0");
        wait_req("rr1");
        chk("rr1_num", 32'(bus.msi_num), 32'd2);
        grant("rr1");
        wait_req("rr2");
        chk("rr2_num", 32'(bus.msi_num), 32'd7);
        grant("rr2");
        step();
        chk("rr_done_req", 32'(bus.msi_req), 32'd0);
        chk("rr_done_pend", bus.pending, 32'd0);

        // Drop counter saturation (count is 3 here)
        for (int i = 0; i < 12; i++) beat(8'd255);
        chk("sat_reach", 32'(bus.drop_count), 32'd15);
        beat(8'd32);
        beat(8'd40);
        chk("sat_hold", 32'(bus.drop_count), 32'd15);
        chk("sat_noreq", 32'(bus.msi_req), 32'd0);

        // Mask holds pending; unmask with a same-cycle beat -> two requests for 4
        bus.msi_mask = 32'h0000_0010;
        beat(8'd4);
        step();
        step();
        chk("mask_noreq", 32'(bus.msi_req), 32'd0);
        chk("mask_pend", bus.pending, 32'h0000_0010);
        beat(8'd4);
        chk("mask_coalesce", bus.pending, 32'h0000_0010);
        bus.msi_mask      = '0;
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tdata  = 8'd4;
        step();
        bus.s_axis_tvalid = 1'b0;
        chk("unmask_req", 32'(bus.msi_req), 32'd1);
        chk("unmask_num", 32'(bus.msi_num), 32'd4);
        chk("setwins_pend", bus.pending, 32'h0000_0010);
        grant("unmask");
        step();
        chk("again_req", 32'(bus.msi_req), 32'd1);
        chk("again_num", 32'(bus.msi_num), 32'd4);
        chk("again_pend", bus.pending, 32'd0);
        grant("again");
        step();
        chk("no_third_req", 32'(bus.msi_req), 32'd0);

        // Asynchronous reset while requesting
        beat(8'd6);
        wait_req("arst");
        beat(8'd8);
        chk("arst_pre_req", 32'(bus.msi_req), 32'd1);
        chk("arst_pre_pend", bus.pending, 32'h0000_0100);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req", 32'(bus.msi_req), 32'd0);
        chk("arst_tready", 32'(bus.s_axis_tready), 32'd0);
        chk("arst_pend", bus.pending, 32'd0);
        chk("arst_drop", 32'(bus.drop_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("arst_rel_tready0", 32'(bus.s_axis_tready), 32'd0);
        step();
        chk("arst_rel_tready1", 32'(bus.s_axis_tready), 32'd1);
        chk("arst_rel_req", 32'(bus.msi_req), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
